// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM state type, frame constants
//                and bit-period helper used by both transmitter and receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmit/receive frame phases
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    // Both ends of the link must derive the bit period identically
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Width of a counter that spans 0..n-1, never narrower than one bit
    function automatic int unsigned counter_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Small single-clock FIFO. Read data is presented
//                combinationally from the read pointer (show-ahead).
//                Pushes while full and pops while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic push_ok;
    logic pop_ok;

    // Status is derived from the registered occupancy only
    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_buffered
//  Description : 8N1 UART transmitter fed by a valid/ready byte FIFO.
//                Queued bytes are sent back-to-back with no idle gap.
//                The serial line is driven from a register one cycle
//                behind the FSM state so it is glitch-free.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W        = counter_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_DATA_IDX   = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP_IDX   = 3'(STOP_BITS - 1);

    uart_state_e      state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             busy_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             bit_end;
    logic             stop_end;

    assign bit_end  = (baud_cnt_q == BAUD_LAST);
    assign stop_end = (state_q == STOP) && bit_end && (bit_idx_q == LAST_STOP_IDX);
    // Pop only when idle or on the final stop-bit cycle, never from an empty FIFO
    assign fifo_pop = ~fifo_empty && ((state_q == IDLE) || stop_end);

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (valid_i),
        .pop   (fifo_pop),
        .din   (data_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_o)
    );

    assign ready_o = ~fifo_full;
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;

    // Frame sequencer: state, baud timing, bit index, shift register and registered line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            // Line level follows the state being occupied this cycle
            case (state_q)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= shift_q[0];
                default: tx_q <= 1'b1;
            endcase

            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        shift_q    <= fifo_dout;
                        state_q    <= START;
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        state_q    <= DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        shift_q    <= shift_q >> 1;
                        if (bit_idx_q == LAST_DATA_IDX) begin
                            bit_idx_q <= '0;
                            state_q   <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == LAST_STOP_IDX) begin
                            bit_idx_q <= '0;
                            // Chain straight into the next frame when data is waiting
                            if (fifo_pop) begin
                                shift_q <= fifo_dout;
                                state_q <= START;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_buffered
//  Description : Self-checking bench for uart_tx_buffered. Accepted bytes
//                go into a scoreboard queue; an independent mid-bit
//                sampling receiver decodes tx_o and compares each frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DEPTH    = 4;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int FRAME    = 10 * CPB;
    localparam int TIMEOUT  = 20000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [$clog2(DEPTH):0] fifo_count_o;

    uart_tx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int pcyc   = 0;
    int ncyc   = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    always @(posedge clk) pcyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference receiver: detect start edge, sample each bit at its centre
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    always @(negedge clk) begin
        ncyc++;
        if (!reset) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx_o === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                starts.push_back(ncyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == HALF) begin
                chk("start_bit", {31'd0, tx_o}, 32'd0);
            end else if (mon_cnt > HALF && mon_cnt < HALF + 9 * CPB && (mon_cnt - HALF) % CPB == 0) begin
                mon_byte = {tx_o, mon_byte[7:1]};
            end else if (mon_cnt == HALF + 9 * CPB) begin
                chk("stop_bit", {31'd0, tx_o}, 32'd1);
                chk("frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    chk("rx_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                end
                mon_act = 1'b0;
            end
        end
    end

    // Offer a byte with valid held until the handshake completes
    task automatic send(input logic [7:0] b, output int acc_cyc);
        bit acc;
        int guard;
        guard   = 0;
        acc_cyc = -1;
        data_i  = b;
        valid_i = 1'b1;
        while (acc_cyc < 0) begin
            acc = ready_o;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_cyc = pcyc;
            end else begin
                guard++;
                if (guard > TIMEOUT) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL send_timeout: byte 0x%0h never accepted", b);
                    break;
                end
            end
        end
        if (acc_cyc >= 0) exp_q.push_back(b);
        valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy_o || mon_act) && guard < TIMEOUT) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("drain_timeout", {31'd0, guard >= TIMEOUT}, 32'd0);
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int cyc);
        while (pcyc < cyc) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int k, a, lows;
        int acc1, acc6;
        logic [7:0] dirs[4];

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk("reset_tx", {31'd0, tx_o}, 32'd1);
        chk("reset_ready", {31'd0, ready_o}, 32'd1);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_count", {29'd0, fifo_count_o}, 32'd0);
        reset = 1'b1;
        lows = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_o !== 1'b1) lows++;
        end
        chk("idle_line_high", lows, 0);
        @(posedge clk);
        #1;

        // Single byte: latency and busy window
        send(8'h81, k);
        @(posedge clk); #1;
        chk("latency_k1_tx", {31'd0, tx_o}, 32'd1);
        @(posedge clk); #1;
        chk("latency_k2_tx", {31'd0, tx_o}, 32'd0);
        wait_until(k + FRAME);
        chk("busy_last_stop", {31'd0, busy_o}, 32'd1);
        wait_until(k + FRAME + 1);
        chk("busy_after_frame", {31'd0, busy_o}, 32'd0);
        wait_drain();

        // Back-to-back frames are contiguous
        starts.delete();
        send(8'h26, a);
        send(8'h88, a);
        wait_drain();
        chk("b2b_frames", starts.size(), 2);
        if (starts.size() == 2) chk("b2b_gap", starts[1] - starts[0], FRAME);

        // Fill the FIFO, then stall a sixth byte against full
        send(8'h01, acc1);
        for (int i = 2; i <= 5; i++) send(8'(i), a);
        chk("full_count", {29'd0, fifo_count_o}, DEPTH);
        chk("full_ready", {31'd0, ready_o}, 32'd0);
        send(8'h06, acc6);
        chk("stall_accept_cycle", acc6 - acc1, FRAME + 2);
        wait_drain();

        // Reset during data bit 3 with bytes queued
        send(8'hA5, k);
        send(8'h11, a);
        send(8'h22, a);
        wait_until(k + 2 + 4 * CPB + 3);
        chk("queued_before_reset", {29'd0, fifo_count_o}, 32'd2);
        chk("bit3_low", {31'd0, tx_o}, 32'd0);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_tx", {31'd0, tx_o}, 32'd1);
        chk("midreset_count", {29'd0, fifo_count_o}, 32'd0);
        chk("midreset_busy", {31'd0, busy_o}, 32'd0);
        chk("midreset_ready", {31'd0, ready_o}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_o !== 1'b1) lows++;
        end
        chk("post_reset_idle", lows, 0);
        chk("post_reset_count", {29'd0, fifo_count_o}, 32'd0);
        @(posedge clk);
        #1;

        // Sampling patterns
        dirs[0] = 8'h00; dirs[1] = 8'hFF; dirs[2] = 8'h55; dirs[3] = 8'hAA;
        for (int i = 0; i < 4; i++) send(dirs[i], a);
        wait_drain();

        // Random bytes with random spacing
        for (int i = 0; i < 30; i++) begin
            send(8'($urandom_range(0, 255)), a);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
